// File: rtl/sparse_sel_sequencer_pkg.sv
// Shared types and constants for the sparse select-code sequencer:
// FSM state encoding, the sparse code table and its lookup helper.
package sparse_sel_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DWELL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Width of the dwell counter (DWELL is limited to 0..255)
   localparam int CNT_W = 8;

   // Sparse case-select codes, entry 0 issued first
   localparam int CODE_NUM = 6;
   localparam int CODE_W   = 8;
   localparam logic [CODE_NUM-1:0][CODE_W-1:0] CODE = {
      8'd59, 8'd57, 8'd55, 8'd49, 8'd47, 8'd45
   };

   // Table lookup; indices past the end of the table read as zero so an
   // out-of-range request never produces an X or an array bound error.
   function automatic logic [CODE_W-1:0] code_at(input int i);
      logic [CODE_W-1:0] r;
      r = '0;
      for (int k = 0; k < CODE_NUM; k++) begin
         if (i == k) begin
            r = CODE[k];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sparse_sel_sequencer_if.sv
// Valid/ready select-code channel between the sequencer and the
// downstream case-mux stage.
interface sparse_sel_sequencer_if #(
   parameter int SEL_W = 6,
   parameter int IDX_W = 3
);
   logic             sel_valid;
   logic             sel_ready;
   logic [SEL_W-1:0] sel_code;
   logic [IDX_W-1:0] sel_idx;

   // Sequencer side: offers codes, observes acceptance
   modport master (
      output sel_valid,
      output sel_code,
      output sel_idx,
      input  sel_ready
   );

   // Case-mux side: consumes codes, signals acceptance
   modport slave (
      input  sel_valid,
      input  sel_code,
      input  sel_idx,
      output sel_ready
   );
endinterface

// File: rtl/sparse_sel_sequencer_dwell_counter.sv
// Down-counter that times the hold gap after each accepted code.
// It loads a start value, counts down to zero and then parks there.
module dwell_counter
   import sparse_sel_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_reg;

   // Clear dominates load, load dominates decrement; never wraps below 0
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/sparse_sel_sequencer.sv
// Sparse select-code sequencer: on start, walks the code table once,
// offering each code on a valid/ready channel and holding for DWELL
// cycles after every accepted code, then pulses done. abort and rst
// both drop the run immediately without a done pulse.
module sparse_sel_sequencer
   import sparse_sel_pkg::*;
#(
   parameter int SEL_W  = 6,
   parameter int NCODES = 6,
   parameter int DWELL  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   sparse_sel_sequencer_if.master       sel,
   output logic                         busy,
   output logic                         done
);

   localparam int IDX_W = (NCODES > 1) ? $clog2(NCODES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCODES - 1);

   // A zero dwell skips the hold state entirely
   localparam bit DWELL_EN = (DWELL > 0);
   localparam logic [CNT_W-1:0] DWELL_LOAD = DWELL_EN ? CNT_W'(DWELL - 1) : '0;

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [SEL_W-1:0] sel_code_reg;
   logic             sel_valid_reg;
   logic             busy_reg;
   logic             done_reg;

   logic             hs;
   logic             step;
   logic             is_last;
   logic             cnt_zero;
   logic             cnt_load;
   logic             cnt_dec;
   logic [IDX_W-1:0] idx_inc;
   logic [SEL_W-1:0] code_first;
   logic [SEL_W-1:0] code_inc;

   // Handshake on the offered code
   assign hs = (state_reg == S_ISSUE) && sel_valid_reg && sel.sel_ready;

   // Advance to the next code (or finish): straight from the handshake
   // when there is no dwell, otherwise once the hold gap has expired.
   assign step = (hs && !DWELL_EN) || ((state_reg == S_DWELL) && cnt_zero);

   assign is_last    = (idx_reg == LAST_IDX);
   assign idx_inc    = idx_reg + IDX_W'(1);
   assign code_first = SEL_W'(code_at(0));
   assign code_inc   = SEL_W'(code_at(int'(idx_inc)));

   // Counter is armed by the handshake and runs down only while holding
   assign cnt_load = hs && DWELL_EN && !abort;
   assign cnt_dec  = (state_reg == S_DWELL) && !cnt_zero;

   dwell_counter #(
      .W (CNT_W)
   ) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .clear    (abort),
      .load     (cnt_load),
      .load_val (DWELL_LOAD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Sequencer FSM with all outputs registered; rst beats abort beats
   // everything else, so an abort also wins over a same-cycle handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         idx_reg       <= '0;
         sel_code_reg  <= '0;
         sel_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else if (abort) begin
         state_reg     <= S_IDLE;
         idx_reg       <= '0;
         sel_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else if (step) begin
         if (is_last) begin
            state_reg     <= S_DONE;
            sel_valid_reg <= 1'b0;
            done_reg      <= 1'b1;
         end else begin
            state_reg     <= S_ISSUE;
            idx_reg       <= idx_inc;
            sel_code_reg  <= code_inc;
            sel_valid_reg <= 1'b1;
         end
      end else begin
         case (state_reg)
            S_IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg     <= S_ISSUE;
                  idx_reg       <= '0;
                  sel_code_reg  <= code_first;
                  sel_valid_reg <= 1'b1;
                  busy_reg      <= 1'b1;
               end
            end
            S_ISSUE: begin
               // Only reached with a non-zero dwell; code holds during the gap
               if (hs) begin
                  state_reg     <= S_DWELL;
                  sel_valid_reg <= 1'b0;
               end
            end
            S_DWELL: begin
               // Waiting for the counter; step handles the exit
               state_reg <= S_DWELL;
            end
            S_DONE: begin
               state_reg <= S_IDLE;
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg     <= S_IDLE;
               sel_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               done_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign sel.sel_valid = sel_valid_reg;
   assign sel.sel_code  = sel_code_reg;
   assign sel.sel_idx   = idx_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;

endmodule

// File: tb/tb_sparse_sel_sequencer.sv
// Directed bench for the sparse select-code sequencer. dut0 runs with a
// dwell of 2, dut1 with a dwell of 0. Cycle n is the period following
// clock edge n; outputs are sampled 1 time unit after the edge.
module tb_sparse_sel_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, start0, abort0, busy0, done0;
   logic rst1, start1, abort1, busy1, done1;

   sparse_sel_sequencer_if #(.SEL_W(6), .IDX_W(3)) bus0 ();
   sparse_sel_sequencer_if #(.SEL_W(6), .IDX_W(3)) bus1 ();

   sparse_sel_sequencer #(.SEL_W(6), .NCODES(6), .DWELL(2)) dut0 (
      .clk   (clk),
      .rst   (rst0),
      .start (start0),
      .abort (abort0),
      .sel   (bus0.master),
      .busy  (busy0),
      .done  (done0)
   );

   sparse_sel_sequencer #(.SEL_W(6), .NCODES(6), .DWELL(0)) dut1 (
      .clk   (clk),
      .rst   (rst1),
      .start (start1),
      .abort (abort1),
      .sel   (bus1.master),
      .busy  (busy1),
      .done  (done1)
   );

   int total = 0;
   int bad   = 0;
   int exp_code [6] = '{45, 47, 49, 55, 57, 59};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b1; start0 = 1'b0; abort0 = 1'b0; bus0.sel_ready = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; abort1 = 1'b0; bus1.sel_ready = 1'b0;
      tick(); tick(); tick();
      total++;
      if ({bus0.sel_valid, bus0.sel_code, bus0.sel_idx, busy0, done0} !== 12'd0) begin
         bad++;
         $display("FAIL reset_dut0: got %b want 0", {bus0.sel_valid, bus0.sel_code, bus0.sel_idx, busy0, done0});
      end
      total++;
      if ({bus1.sel_valid, bus1.sel_code, bus1.sel_idx, busy1, done1} !== 12'd0) begin
         bad++;
         $display("FAIL reset_dut1: got %b want 0", {bus1.sel_valid, bus1.sel_code, bus1.sel_idx, busy1, done1});
      end
      rst0 = 1'b0; rst1 = 1'b0;
      tick(); tick();
      total++;
      if (busy0 !== 1'b0 || bus0.sel_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got busy=%b valid=%b want 0 0", busy0, bus0.sel_valid);
      end
      $display("reset: both sequencers idle");
   endtask

   // Dwell 2, ready held high: codes at 1,4,...,16, done only at 19
   task automatic test_nominal();
      bit ev, ed, eb;
      int ei;
      bus0.sel_ready = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 21; c++) begin
         ev = (c <= 16) && ((c - 1) % 3 == 0);
         ei = (c - 1) / 3;
         ed = (c == 19);
         eb = (c <= 19);
         total++;
         if (bus0.sel_valid !== ev) begin
            bad++; $display("FAIL nominal_valid cycle %0d: got %b want %b", c, bus0.sel_valid, ev);
         end
         if (ev) begin
            total++;
            if (bus0.sel_code !== 6'(exp_code[ei]) || bus0.sel_idx !== 3'(ei)) begin
               bad++; $display("FAIL nominal_code cycle %0d: got %0d/%0d want %0d/%0d", c, bus0.sel_code, bus0.sel_idx, exp_code[ei], ei);
            end
            $display("nominal: cycle %0d code %0d idx %0d", c, bus0.sel_code, bus0.sel_idx);
         end
         total++;
         if (done0 !== ed || busy0 !== eb) begin
            bad++; $display("FAIL nominal_done_busy cycle %0d: got %b%b want %b%b", c, done0, busy0, ed, eb);
         end
         tick();
      end
      bus0.sel_ready = 1'b0;
   endtask

   // Ready low while idx 2 is offered (cycles 7..11); run resumes at 12
   task automatic test_stall();
      bit ev, ed, eb;
      int ei;
      start0 = 1'b1;
      bus0.sel_ready = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         bus0.sel_ready = !(c >= 5 && c <= 11);
         ev = 1'b0; ei = 0;
         if (c >= 7 && c <= 12) begin ev = 1'b1; ei = 2; end
         else if (c < 7 && (c - 1) % 3 == 0) begin ev = 1'b1; ei = (c - 1) / 3; end
         else if (c > 12 && c <= 21 && c % 3 == 0) begin ev = 1'b1; ei = (c - 15) / 3 + 3; end
         ed = (c == 24);
         eb = (c <= 24);
         total++;
         if (bus0.sel_valid !== ev) begin
            bad++; $display("FAIL stall_valid cycle %0d: got %b want %b", c, bus0.sel_valid, ev);
         end
         if (ev) begin
            total++;
            if (bus0.sel_code !== 6'(exp_code[ei]) || bus0.sel_idx !== 3'(ei)) begin
               bad++; $display("FAIL stall_code cycle %0d: got %0d/%0d want %0d/%0d", c, bus0.sel_code, bus0.sel_idx, exp_code[ei], ei);
            end
         end
         total++;
         if (done0 !== ed || busy0 !== eb) begin
            bad++; $display("FAIL stall_done_busy cycle %0d: got %b%b want %b%b", c, done0, busy0, ed, eb);
         end
         tick();
      end
      $display("stall: code 49 held through 5 not-ready cycles");
      bus0.sel_ready = 1'b0;
   endtask

   // Abort during the hold after idx 3, then restart from code 45
   task automatic test_abort();
      bus0.sel_ready = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c < 11; c++) tick();
      total++;
      if (bus0.sel_valid !== 1'b0 || bus0.sel_idx !== 3'd3 || busy0 !== 1'b1) begin
         bad++; $display("FAIL abort_pre cycle 11: got valid=%b idx=%0d busy=%b want 0 3 1", bus0.sel_valid, bus0.sel_idx, busy0);
      end
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      total++;
      if (busy0 !== 1'b0 || bus0.sel_valid !== 1'b0) begin
         bad++; $display("FAIL abort_effect cycle 12: got busy=%b valid=%b want 0 0", busy0, bus0.sel_valid);
      end
      for (int c = 12; c < 20; c++) begin
         total++;
         if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            bad++; $display("FAIL abort_quiet cycle %0d: got done=%b busy=%b want 0 0", c, done0, busy0);
         end
         tick();
      end
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      total++;
      if (bus0.sel_valid !== 1'b1 || bus0.sel_code !== 6'd45 || bus0.sel_idx !== 3'd0) begin
         bad++; $display("FAIL abort_restart: got valid=%b code=%0d idx=%0d want 1 45 0", bus0.sel_valid, bus0.sel_code, bus0.sel_idx);
      end
      $display("abort: restart issued code %0d", bus0.sel_code);
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      bus0.sel_ready = 1'b0;
      tick();
   endtask

   // One-cycle reset while idx 4 is offered
   task automatic test_rst_mid();
      bus0.sel_ready = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int c = 1; c < 13; c++) tick();
      total++;
      if (bus0.sel_valid !== 1'b1 || bus0.sel_idx !== 3'd4 || bus0.sel_code !== 6'd57) begin
         bad++; $display("FAIL rst_pre cycle 13: got valid=%b idx=%0d code=%0d want 1 4 57", bus0.sel_valid, bus0.sel_idx, bus0.sel_code);
      end
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      total++;
      if ({bus0.sel_valid, bus0.sel_code, bus0.sel_idx, busy0, done0} !== 12'd0) begin
         bad++; $display("FAIL rst_mid cycle 14: got %b want 0", {bus0.sel_valid, bus0.sel_code, bus0.sel_idx, busy0, done0});
      end
      for (int c = 14; c <= 24; c++) begin
         total++;
         if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            bad++; $display("FAIL rst_quiet cycle %0d: got done=%b busy=%b want 0 0", c, done0, busy0);
         end
         tick();
      end
      $display("rst_mid: run discarded");
      bus0.sel_ready = 1'b0;
   endtask

   // start+abort while idle is ignored; start held through a run is ignored
   task automatic test_start_ignored();
      bit ev, ed, eb;
      int ei;
      start0 = 1'b1;
      abort0 = 1'b1;
      tick();
      start0 = 1'b0;
      abort0 = 1'b0;
      total++;
      if (busy0 !== 1'b0 || bus0.sel_valid !== 1'b0) begin
         bad++; $display("FAIL start_with_abort: got busy=%b valid=%b want 0 0", busy0, bus0.sel_valid);
      end
      tick();
      bus0.sel_ready = 1'b1;
      start0 = 1'b1;
      tick();
      for (int c = 1; c <= 21; c++) begin
         start0 = (c <= 19);
         ev = (c <= 16) && ((c - 1) % 3 == 0);
         ei = (c - 1) / 3;
         ed = (c == 19);
         eb = (c <= 19);
         total++;
         if (bus0.sel_valid !== ev) begin
            bad++; $display("FAIL busy_start_valid cycle %0d: got %b want %b", c, bus0.sel_valid, ev);
         end
         if (ev) begin
            total++;
            if (bus0.sel_code !== 6'(exp_code[ei]) || bus0.sel_idx !== 3'(ei)) begin
               bad++; $display("FAIL busy_start_code cycle %0d: got %0d/%0d want %0d/%0d", c, bus0.sel_code, bus0.sel_idx, exp_code[ei], ei);
            end
         end
         total++;
         if (done0 !== ed || busy0 !== eb) begin
            bad++; $display("FAIL busy_start_done_busy cycle %0d: got %b%b want %b%b", c, done0, busy0, ed, eb);
         end
         tick();
      end
      $display("start_ignored: sequence unchanged with start held");
      start0 = 1'b0;
      bus0.sel_ready = 1'b0;
   endtask

   // Dwell 0: six consecutive codes, done at cycle 7
   task automatic test_dwell0();
      bit ev, ed, eb;
      bus1.sel_ready = 1'b1;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         ev = (c <= 6);
         ed = (c == 7);
         eb = (c <= 7);
         total++;
         if (bus1.sel_valid !== ev) begin
            bad++; $display("FAIL dwell0_valid cycle %0d: got %b want %b", c, bus1.sel_valid, ev);
         end
         if (ev) begin
            total++;
            if (bus1.sel_code !== 6'(exp_code[c - 1]) || bus1.sel_idx !== 3'(c - 1)) begin
               bad++; $display("FAIL dwell0_code cycle %0d: got %0d/%0d want %0d/%0d", c, bus1.sel_code, bus1.sel_idx, exp_code[c - 1], c - 1);
            end
            $display("dwell0: cycle %0d code %0d idx %0d", c, bus1.sel_code, bus1.sel_idx);
         end
         total++;
         if (done1 !== ed || busy1 !== eb) begin
            bad++; $display("FAIL dwell0_done_busy cycle %0d: got %b%b want %b%b", c, done1, busy1, ed, eb);
         end
         tick();
      end
      bus1.sel_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      tick(); tick();
      test_stall();
      tick(); tick();
      test_abort();
      tick(); tick();
      test_rst_mid();
      tick(); tick();
      test_start_ignored();
      tick(); tick();
      test_dwell0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
